// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit that sits beside the EX-stage ALU.
// It owns the HI/LO registers. Multiply uses a shift-add scheme and divide uses
// restoring division, each producing one bit per clock.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, op[1:0]        launch request (sampled in IDLE); 00 MULT, 01 MULTU,
//                         10 DIV, 11 DIVU
//   operand_a, operand_b  rs (multiplicand/dividend), rt (multiplier/divisor)
//   hilo_read             MFHI/MFLO present in EX
//   mthi, mtlo            write operand_a into HI / LO (honoured in IDLE only)
//   flush                 abort the in-flight operation
//   hi, lo                HI/LO registers
//   busy, done, stall     not-IDLE, result-write pulse, busy & (hilo_read | start)
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, a multiply stops iterating once the remaining multiplier bits
//   are zero. The partial product is then realigned in FIX.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_read,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [CW-1:0]      cnt_inc;
    logic [WIDTH:0]     mul_sum, div_rem_s;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_al, mul_fix;
    logic [WIDTH-1:0]   div_q, div_r, fix_hi, fix_lo;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    // In PREP, a_q/b_q still hold the raw operands captured in IDLE.
    assign a_neg     = is_signed & a_q[WIDTH-1];
    assign b_neg     = is_signed & b_q[WIDTH-1];
    assign a_mag     = a_neg ? -a_q : a_q;
    assign b_mag     = b_neg ? -b_q : b_q;
    assign cnt_inc   = cnt_q + CW'(1);

    // Multiply step. The multiplier sits in the low half and is consumed from bit 0.
    // The carry out of the upper add re-enters at the top on the right shift.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    assign mul_next = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]}
                                : {1'b0, prod_q[2*WIDTH-1:1]};

    // Divide step. The remainder is in the upper half and the dividend/quotient is
    // in the lower half. The remainder stays below the divisor, so the shifted
    // value fits in WIDTH+1 bits and the difference fits in WIDTH bits.
    assign div_rem_s = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_ge    = div_rem_s >= {1'b0, b_q};
    assign div_sub   = div_rem_s[WIDTH-1:0] - b_q;
    assign div_next  = div_ge ? {div_sub, prod_q[WIDTH-2:0], 1'b1}
                              : {div_rem_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] mul_rest;
    // Multiplier bits not yet consumed after the current iteration.
    assign mul_rest = b_q >> cnt_inc;
    // After cnt_q iterations, the partial product sits WIDTH-cnt_q places too high.
    assign prod_al  = prod_q >> (WIDTH - int'(cnt_q));
`else
    assign prod_al  = prod_q;
`endif

    assign mul_fix = neg_q  ? -prod_al : prod_al;
    assign div_q   = neg_q  ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign div_r   = rneg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    assign fix_hi  = is_div ? div_r : mul_fix[2*WIDTH-1:WIDTH];
    assign fix_lo  = is_div ? div_q : mul_fix[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = operand_a;
                if (mtlo) lo_d = operand_a;
                if (start && !flush) begin
                    op_d    = op;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d    = a_mag;
                    b_d    = b_mag;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = '0;
                    prod_d = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    if (is_div && b_q == '0) begin
                        hi_d    = a_q;
                        lo_d    = '1;
                        state_d = S_DONE;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if (!is_div && b_mag == '0) begin
                        state_d = S_FIX;
`endif
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = is_div ? div_next : mul_next;
                    cnt_d  = cnt_inc;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                    else if (!is_div && mul_rest == '0) state_d = S_FIX;
`endif
                end
            end
            S_FIX: begin
                // HI/LO are committed on the FIX->DONE edge.
                // This makes them valid in the same cycle that done is high.
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign stall = busy & (hilo_read | start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, hilo_read, mthi, mtlo, flush;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .hilo_read(hilo_read),
        .mthi(mthi), .mtlo(mtlo), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model computed directly from the arithmetic definitions.
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl, output int lat);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0]        p;
        logic [31:0]        mag;
        int                 msb;
        sa  = $signed(a);
        sb  = $signed(b);
        lat = 35;
        rh  = '0;
        rl  = '0;
        case (o)
            2'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
            2'd2: begin
                if (b == 0) begin rl = '1; rh = a; lat = 2; end
                else begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
            end
            default: begin
                if (b == 0) begin rl = '1; rh = a; lat = 2; end
                else begin rl = a / b; rh = a % b; end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            mag = (o == 2'd0 && b[31]) ? -b : b;
            msb = -1;
            for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
            lat = (msb < 0) ? 3 : 4 + msb;
        end
`else
        mag = '0;
        msb = 0;
        if (mag != 0 || msb != 0) lat = 0;
`endif
    endfunction

    // Caller is positioned at #1 after a rising edge.
    // lat is the cycle in which done is observed (the start-sampling edge opens cycle 1).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output int lat);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
        if (!done) lat = -1;
        rh = hi;
        rl = lo;
        step();
        chk("done_single_cycle", {63'b0, done}, 64'd0);
        chk("busy_after_done", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rh, rl, eh, el, ph, pl;
        int          lat, elat;
        logic        seen_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        tbl[0]  = '{2'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5]  = '{2'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        tbl[6]  = '{2'd1, 32'd5,        32'd1,        32'd0,        32'd5};
        tbl[7]  = '{2'd1, 32'd5,        32'd0,        32'd0,        32'd0};
        tbl[8]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        tbl[9]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[10] = '{2'd2, 32'd0,        32'd5,        32'd0,        32'd0};
        tbl[11] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tbl[12] = '{2'd2, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
        tbl[13] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

        rst_n = 1'b0; start = 0; hilo_read = 0; mthi = 0; mtlo = 0; flush = 0;
        op = 0; operand_a = 0; operand_b = 0;
        step(); step();
        chk("reset_hi", {32'b0, hi}, 64'd0);
        chk("reset_lo", {32'b0, lo}, 64'd0);
        chk("reset_ctl", {61'b0, busy, done, stall}, 64'd0);
        rst_n = 1'b1;
        step();

        // IDLE-side behaviour: MTHI/MTLO, read without stall, flush beats start.
        operand_a = 32'hA5A50001; mthi = 1'b1; step(); mthi = 1'b0;
        chk("mthi_idle", {32'b0, hi}, 64'hA5A50001);
        operand_a = 32'h5A5A0002; mtlo = 1'b1; step(); mtlo = 1'b0;
        chk("mtlo_idle", {32'b0, lo}, 64'h5A5A0002);
        hilo_read = 1'b1; #1;
        chk("stall_idle_read", {63'b0, stall}, 64'd0);
        hilo_read = 1'b0;
        start = 1'b1; flush = 1'b1; op = 2'd1; operand_b = 32'd3; step();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle", {63'b0, busy}, 64'd0);

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            ref_op(tbl[i].op, tbl[i].a, tbl[i].b, eh, el, elat);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, rh, rl, lat);
            chk($sformatf("tbl%0d_hi", i), {32'b0, rh}, {32'b0, tbl[i].hi});
            chk($sformatf("tbl%0d_lo", i), {32'b0, rl}, {32'b0, tbl[i].lo});
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(elat));
        end

        // Stall while busy, plus MTHI/start ignored while in flight.
        ref_op(2'd1, 32'h12345678, 32'h80000001, ph, pl, elat);
        op = 2'd1; operand_a = 32'h12345678; operand_b = 32'h80000001; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            hilo_read = (c >= 5);
            mthi      = (c == 10 || c == 35);
            start     = (c == 20);
            operand_a = (c == 10 || c == 35) ? 32'hDEADBEEF : 32'h12345678;
            #1;
            chk($sformatf("stall_c%0d", c), {63'b0, stall}, {63'b0, (c >= 5 && c <= 35)});
            chk($sformatf("done_c%0d", c), {63'b0, done}, {63'b0, (c == 35)});
            step();
        end
        hilo_read = 0; mthi = 0; start = 0;
        chk("busy_hilo_hi", {32'b0, hi}, {32'b0, ph});
        chk("busy_hilo_lo", {32'b0, lo}, {32'b0, pl});

        // Flush mid-divide: return to IDLE, HI/LO untouched, no done pulse.
        op = 2'd3; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            seen_done |= done;
            if (c == 12) flush = 1'b1;
            step();
        end
        flush = 1'b0;
        chk("flush_idle", {63'b0, busy}, 64'd0);
        for (int c = 0; c < 40; c++) begin
            seen_done |= done;
            step();
        end
        chk("flush_no_done", {63'b0, seen_done}, 64'd0);
        chk("flush_hi_kept", {32'b0, hi}, {32'b0, ph});
        chk("flush_lo_kept", {32'b0, lo}, {32'b0, pl});

        // Asynchronous reset mid-ITER clears outputs without waiting for a clock edge.
        op = 2'd1; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        hilo_read = 1'b1; #1;
        chk("pre_reset_stall", {63'b0, stall}, 64'd1);
        rst_n = 1'b0; #1;
        chk("areset_hi", {32'b0, hi}, 64'd0);
        chk("areset_lo", {32'b0, lo}, 64'd0);
        chk("areset_ctl", {61'b0, busy, done, stall}, 64'd0);
        #1 rst_n = 1'b1; hilo_read = 1'b0;
        step();
        chk("post_reset_idle", {63'b0, busy}, 64'd0);

        // Randomized operations checked against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            ref_op(ro, ra, rb, eh, el, elat);
            run_op(ro, ra, rb, rh, rl, lat);
            chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, ro, ra, rb), {32'b0, rh}, {32'b0, eh});
            chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, ro, ra, rb), {32'b0, rl}, {32'b0, el});
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU beside the single-cycle ALU in the EX stage.
- Runs an iterative shift-add multiplier or a restoring divider, one bit per clock.
- Owns the HI/LO registers.
- Raises a pipeline stall when the decoder issues MFHI/MFLO or a new mul/div while an operation is in flight.
- Accepts MTHI/MTLO writes and a flush from exception handling.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch an operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  in  WIDTH  rs value (multiplicand / dividend)
operand_b  in  WIDTH  rt value (multiplier / divisor)
hilo_read  in  1  decoder has MFHI or MFLO in EX
mthi  in  1  write operand_a to HI
mtlo  in  1  write operand_a to LO
flush  in  1  abort in-flight operation
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when HI/LO are updated by an operation
stall  out  1  combinational: busy & (hilo_read | start)

Behaviour:
Reset (rst_n low, asynchronous):
- State returns to IDLE.
- hi, lo, the iteration counter and internal accumulators clear to 0.
- busy, done and stall are 0.

States:
- IDLE: start=1 captures op and both operands, goes to PREP.
- PREP (1 cycle):
  - Signed ops convert operands to magnitude and record the result sign.
  - DIV/DIVU with operand_b==0 goes to DONE with lo=all ones, hi=operand_a (raw, unsigned view).
  - Otherwise goes to ITER with counter=0.
- ITER (WIDTH cycles, one bit per cycle):
  - Multiply: add the multiplicand to the upper accumulator if the multiplier LSB is 1, then shift the 2*WIDTH product right by 1.
  - Divide: shift the remainder left, bringing in the next dividend bit; subtract the divisor if the remainder is >= divisor and set the quotient bit.
  - Counter reaching WIDTH-1 goes to FIX.
- FIX (1 cycle), sign correction:
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- DONE (1 cycle): writes hi/lo (product upper/lower; remainder/quotient), done=1, goes to IDLE.

Latency:
- Normal operation: done is high in cycle WIDTH+3 after the start-sampling edge (35 for WIDTH=32).
- Divide by zero: done in cycle 2.

Boundary conditions:
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
- start while busy: ignored, and stall=1 so the decoder holds the instruction.
- mthi/mtlo:
  - In IDLE: write next edge.
  - While busy: ignored; the decoder keeps them stalled via hilo_read.
- mthi/mtlo in the same cycle as DONE: the DONE result wins.
- flush:
  - While busy: returns to IDLE next edge; hi/lo are unchanged and no done pulse is issued.
  - flush in DONE: the write completes first (DONE has priority).
  - flush and start together in IDLE: start is ignored.
- hilo_read in IDLE: stall=0. The decoder reads hi/lo directly, and the values are valid the same cycle.
- rst_n asserted mid-operation: immediate IDLE, all registers cleared.

Optional Feature:
MULDIV_EARLY_OUT_EN

With the macro defined:
- In multiply ITER, if the remaining unshifted multiplier bits are all zero, go to FIX next cycle.
- The product is aligned by shifting right by the number of skipped iterations.
- Multiply latency is variable: 4 + position of the highest set multiplier-magnitude bit (operand_b magnitude 1 gives done in cycle 4).
- Multiplier 0 goes directly PREP->FIX.

Without the macro: fixed WIDTH+3 latency for every multiply. Divide is unaffected either way.

Test Plan:
1. MULT 0xFFFFFFFE (-2) x 0x00000003 -> done in cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIVU 0x12345678 / 0 -> done in cycle 2, lo=0xFFFFFFFF, hi=0x12345678, busy low from cycle 3.
4. Start MULT, assert hilo_read cycles 5-40 -> stall=1 through cycle 35, 0 from cycle 36; mthi at cycle 10 ignored, hi shows the product.
5. Start DIV, flush at cycle 12 -> IDLE at cycle 13, hi/lo keep prior values, no done; async rst_n pulse mid-ITER -> all outputs 0 immediately.
6. With MULDIV_EARLY_OUT_EN: MULTU 5 x 1 -> done in cycle 4, lo=5; MULTU 5 x 0 -> lo=0, hi=0 with early done. Without the macro both give done in cycle 35.
